// File: rtl/audio_adc_receiver.sv
// I2S ADC capture: deserialises codec L/R words into sample pairs,
// buffers them in a small FIFO and presents them on valid/ready.
//
// Ports:
//   Clk, Reset (async, active-low), enable       : clock, reset, capture enable
//   AUD_BCLK, AUD_ADCLRCK, AUD_ADCDAT            : raw codec serial inputs
//   LData, RData, sample_valid, sample_ready     : FIFO head pair + handshake
//   overflow, framing_err, clear_flags           : sticky status and clear
module audio_adc_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    enable,
  input  logic                    AUD_BCLK,
  input  logic                    AUD_ADCLRCK,
  input  logic                    AUD_ADCDAT,
  output logic [SAMPLE_WIDTH-1:0] LData,
  output logic [SAMPLE_WIDTH-1:0] RData,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overflow,
  output logic                    framing_err,
  input  logic                    clear_flags
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } state_t;

  logic [SYNC_STAGES-1:0] bclk_sync;
  logic [SYNC_STAGES-1:0] lrck_sync;
  logic [SYNC_STAGES-1:0] dat_sync;
  logic                   bclk_q;
  logic                   lr_prev;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_q    <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[SYNC_STAGES-2:0], AUD_BCLK};
      lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], AUD_ADCLRCK};
      dat_sync  <= {dat_sync[SYNC_STAGES-2:0], AUD_ADCDAT};
      bclk_q    <= bclk_sync[SYNC_STAGES-1];
    end
  end

  logic bclk_s;
  logic lr_s;
  logic dat_s;
  logic rise;
  logic lr_edge;

  assign bclk_s  = bclk_sync[SYNC_STAGES-1];
  assign lr_s    = lrck_sync[SYNC_STAGES-1];
  assign dat_s   = dat_sync[SYNC_STAGES-1];
  assign rise    = bclk_s & ~bclk_q;
  assign lr_edge = rise & (lr_s != lr_prev);

  state_t          state_q;
  state_t          state_d;
  logic [SW-1:0]   shreg;
  logic [CW-1:0]   bitcnt;
  logic [SW-1:0]   left_hold;
  logic            chan_r;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else if (rise) begin
      case (state_q)
        IDLE:  if (lr_edge && !lr_s) state_d = DELAY;
        DELAY: state_d = SHIFT;
        SHIFT: begin
          // A falling LRCK mid-word starts a fresh left word at once.
          if (lr_edge)            state_d = lr_s ? IDLE : DELAY;
          else if (bitcnt == LAST) state_d = PAD;
        end
        PAD:   if (lr_edge) state_d = DELAY;
        default: state_d = IDLE;
      endcase
    end
  end

  logic [SW-1:0] shift_word;
  logic          word_done;
  logic          push_req;
  logic          hold_left;
  logic          ferr_set;

  always_comb begin
    shift_word = {shreg[SW-2:0], dat_s};
    word_done  = 1'b0;
    push_req   = 1'b0;
    hold_left  = 1'b0;
    ferr_set   = 1'b0;
    if (enable && rise && state_q == SHIFT) begin
      ferr_set  = lr_edge;
      word_done = !lr_edge && bitcnt == LAST;
      push_req  = word_done & chan_r;
      hold_left = word_done & ~chan_r;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      lr_prev   <= 1'b0;
      shreg     <= '0;
      bitcnt    <= '0;
      left_hold <= '0;
      chan_r    <= 1'b0;
    end else begin
      if (rise) lr_prev <= lr_s;
      if (enable && rise) begin
        if (state_q == DELAY) begin
          shreg  <= '0;
          bitcnt <= '0;
        end else if (state_q == SHIFT && !lr_edge) begin
          shreg  <= shift_word;
          bitcnt <= bitcnt + CW'(1);
        end
      end
      if (hold_left) left_hold <= shift_word;
      // Channel follows the LRCK level that opened the word.
      if (state_d == DELAY && state_q != DELAY) chan_r <= lr_s;
    end
  end

  logic [2*SW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            empty;
  logic            full;
  logic            do_pop;
  logic            do_push;
  logic            ovf_set;
  logic [2*SW-1:0] head;

  assign empty   = wr_ptr == rd_ptr;
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = ~empty & sample_ready;
  assign do_push = push_req & (~full | do_pop);
  assign ovf_set = push_req & full & ~do_pop;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= {left_hold, shift_word};
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  logic ovf_q;
  logic ferr_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ovf_q  <= (ovf_q & ~clear_flags) | ovf_set;
      ferr_q <= (ferr_q & ~clear_flags) | ferr_set;
    end
  end

  assign head         = mem[rd_ptr[AW-1:0]];
  assign LData        = head[2*SW-1:SW];
  assign RData        = head[SW-1:0];
  assign sample_valid = ~empty;
  assign overflow     = ovf_q;
  assign framing_err  = ferr_q;

endmodule

// File: tb/tb_audio_adc_receiver.sv
// Directed bench for audio_adc_receiver: I2S frames driven at Clk/16,
// expected pairs and flags hand-computed per step.
module tb_audio_adc_receiver;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        enable = 1'b0;
  logic        AUD_BCLK = 1'b0;
  logic        AUD_ADCLRCK = 1'b0;
  logic        AUD_ADCDAT = 1'b0;
  logic [15:0] LData;
  logic [15:0] RData;
  logic        sample_valid;
  logic        sample_ready = 1'b0;
  logic        overflow;
  logic        framing_err;
  logic        clear_flags = 1'b0;

  int n_pass  = 0;
  int n_total = 0;

  always #5 Clk = ~Clk;

  audio_adc_receiver dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .enable       (enable),
    .AUD_BCLK     (AUD_BCLK),
    .AUD_ADCLRCK  (AUD_ADCLRCK),
    .AUD_ADCDAT   (AUD_ADCDAT),
    .LData        (LData),
    .RData        (RData),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overflow     (overflow),
    .framing_err  (framing_err),
    .clear_flags  (clear_flags)
  );

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // One channel word of nbits BCLK periods. The rise where LRCK first
  // shows the new level is bit 0, bit 1 is the one-bit delay, MSB at 2.
  task automatic send_word(input logic lr, input logic [15:0] d,
                           input int nbits, input int dis_at,
                           input int rdy_at);
    for (int k = 0; k < nbits; k++) begin
      @(negedge Clk);
      AUD_BCLK    = 1'b0;
      AUD_ADCLRCK = lr;
      AUD_ADCDAT  = (k >= 2 && k < 18) ? d[17-k] : 1'b0;
      if (k == dis_at) begin
        enable = 1'b0;
        repeat (3) @(negedge Clk);
        enable = 1'b1;
        repeat (5) @(negedge Clk);
      end else begin
        repeat (8) @(negedge Clk);
      end
      AUD_BCLK = 1'b1;
      if (k == rdy_at) begin
        // Two sync stages: rise is seen in the cycle after the 2nd posedge.
        @(posedge Clk);
        @(posedge Clk);
        #1 sample_ready = 1'b1;
        @(posedge Clk);
        #1 sample_ready = 1'b0;
        repeat (5) @(negedge Clk);
      end else begin
        repeat (7) @(negedge Clk);
      end
    end
  endtask

  task automatic frame(input logic [15:0] l, input logic [15:0] r,
                       input int rdy_at);
    send_word(1'b0, l, 32, -1, -1);
    send_word(1'b1, r, 32, -1, rdy_at);
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] l,
                            input logic [15:0] r);
    @(negedge Clk);
    check({tag, "_valid"}, {15'd0, sample_valid}, 16'd1);
    check({tag, "_L"}, LData, l);
    check({tag, "_R"}, RData, r);
    sample_ready = 1'b1;
    @(negedge Clk);
    sample_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge Clk);
    clear_flags = 1'b1;
    @(negedge Clk);
    clear_flags = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge Clk);
    check("rst_L", LData, 16'h0000);
    check("rst_R", RData, 16'h0000);
    check("rst_valid", {15'd0, sample_valid}, 16'd0);
    check("rst_ovf", {15'd0, overflow}, 16'd0);
    check("rst_ferr", {15'd0, framing_err}, 16'd0);
    Reset  = 1'b1;
    enable = 1'b1;

    // Basic pair.
    send_word(1'b1, 16'h0000, 4, -1, -1);
    frame(16'hA5C3, 16'h0F01, -1);
    check("t1_ovf", {15'd0, overflow}, 16'd0);
    check("t1_ferr", {15'd0, framing_err}, 16'd0);
    pop_expect("t1", 16'hA5C3, 16'h0F01);
    @(negedge Clk);
    check("t1_empty", {15'd0, sample_valid}, 16'd0);

    // Overflow with consumer stalled.
    for (int i = 1; i <= 6; i++) begin
      frame(16'(i), 16'h8000 | 16'(i), -1);
      if (i == 4) check("t2_ovf4", {15'd0, overflow}, 16'd0);
      if (i == 5) check("t2_ovf5", {15'd0, overflow}, 16'd1);
    end
    @(negedge Clk);
    for (int i = 1; i <= 4; i++) begin
      check("t2_valid", {15'd0, sample_valid}, 16'd1);
      check("t2_L", LData, 16'(i));
      check("t2_R", RData, 16'h8000 | 16'(i));
      sample_ready = 1'b1;
      @(negedge Clk);
    end
    check("t2_empty", {15'd0, sample_valid}, 16'd0);
    sample_ready = 1'b0;
    pulse_clear();
    check("t2_ovf_clr", {15'd0, overflow}, 16'd0);

    // Push and pop on the same cycle while full.
    for (int i = 1; i <= 4; i++)
      frame(16'h0010 | 16'(i), 16'h8010 | 16'(i), -1);
    frame(16'h0015, 16'h8015, 17);
    check("t3_ovf", {15'd0, overflow}, 16'd0);
    pop_expect("t3a", 16'h0012, 16'h8012);
    pop_expect("t3b", 16'h0013, 16'h8013);
    pop_expect("t3c", 16'h0014, 16'h8014);
    pop_expect("t3d", 16'h0015, 16'h8015);
    @(negedge Clk);
    check("t3_empty", {15'd0, sample_valid}, 16'd0);

    // Short right word, then resync on the same falling LRCK.
    send_word(1'b0, 16'h2222, 32, -1, -1);
    send_word(1'b1, 16'h3333, 10, -1, -1);
    frame(16'h1234, 16'h5678, -1);
    check("t4_ferr", {15'd0, framing_err}, 16'd1);
    check("t4_ovf", {15'd0, overflow}, 16'd0);
    pop_expect("t4", 16'h1234, 16'h5678);
    @(negedge Clk);
    check("t4_empty", {15'd0, sample_valid}, 16'd0);
    pulse_clear();
    check("t4_ferr_clr", {15'd0, framing_err}, 16'd0);

    // Mid-right start, enable dropped mid-left word.
    send_word(1'b1, 16'hFFFF, 8, -1, -1);
    send_word(1'b0, 16'h3333, 32, 10, -1);
    send_word(1'b1, 16'h4444, 32, -1, -1);
    @(negedge Clk);
    check("t5_nopush", {15'd0, sample_valid}, 16'd0);
    check("t5_ferr", {15'd0, framing_err}, 16'd0);
    frame(16'hABCD, 16'h1357, -1);
    pop_expect("t5", 16'hABCD, 16'h1357);
    @(negedge Clk);
    check("t5_empty", {15'd0, sample_valid}, 16'd0);

    // Asynchronous reset mid-shift with two pairs buffered.
    frame(16'h0A0A, 16'h0B0B, -1);
    frame(16'h0C0C, 16'h0D0D, -1);
    @(negedge Clk);
    check("t6_pre_valid", {15'd0, sample_valid}, 16'd1);
    check("t6_pre_L", LData, 16'h0A0A);
    send_word(1'b0, 16'h5555, 12, -1, -1);
    @(negedge Clk);
    #3 Reset = 1'b0;
    #1;
    check("t6_rst_L", LData, 16'h0000);
    check("t6_rst_R", RData, 16'h0000);
    check("t6_rst_valid", {15'd0, sample_valid}, 16'd0);
    check("t6_rst_ovf", {15'd0, overflow}, 16'd0);
    check("t6_rst_ferr", {15'd0, framing_err}, 16'd0);
    @(negedge Clk);
    Reset = 1'b1;
    send_word(1'b0, 16'h5555, 20, -1, -1);
    send_word(1'b1, 16'h6666, 32, -1, -1);
    @(negedge Clk);
    check("t6_nopush", {15'd0, sample_valid}, 16'd0);
    frame(16'h7E57, 16'h1CE5, -1);
    pop_expect("t6", 16'h7E57, 16'h1CE5);
    @(negedge Clk);
    check("t6_empty", {15'd0, sample_valid}, 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/audio_adc_receiver.md
Name: audio_adc_receiver

Overview:
- Capture side of the codec audio path. Deserialises the I2S ADC stream from the codec (AUD_ADCDAT, framed by AUD_ADCLRCK and AUD_BCLK) into 16-bit left/right sample pairs.
- Completed pairs are buffered in a small FIFO and presented to a consumer (game logic, level meter, loopback) on a valid/ready interface.
- Counterpart of the DAC-side sample feed: samples are read from the codec instead of being written to it.

Parameters:
- SAMPLE_WIDTH, 16: bits per channel captured, MSB first.
- FIFO_DEPTH, 4: stereo pairs buffered; power of two, minimum 2.
- SYNC_STAGES, 2: flip-flop stages on each codec input before edge detection.

Ports:
- Clk  in  1  system clock (50 MHz); AUD_BCLK must be no faster than Clk/8.
- Reset  in  1  asynchronous, active-low reset.
- enable  in  1  capture enable.
- AUD_BCLK  in  1  codec bit clock, asynchronous to Clk.
- AUD_ADCLRCK  in  1  codec ADC frame clock; low = left, high = right.
- AUD_ADCDAT  in  1  codec serial ADC data.
- LData  out  SAMPLE_WIDTH  left sample at FIFO head.
- RData  out  SAMPLE_WIDTH  right sample at FIFO head.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer accepts head pair.
- overflow  out  1  sticky: a completed pair was dropped because the FIFO was full.
- framing_err  out  1  sticky: a channel ended before SAMPLE_WIDTH bits were captured.
- clear_flags  in  1  clears overflow and framing_err.

Behaviour:
- Reset (asynchronous, Reset=0):
  - All outputs 0, FIFO empty, FSM in IDLE, synchronisers 0.
  - Outputs stay 0 until the first pair is pushed.
- Input conditioning:
  - BCLK, LRCK and DAT each pass through SYNC_STAGES flops.
  - rise = synchronised BCLK 0->1 across consecutive Clk cycles. All serial activity happens only on rise cycles, using synchronised LRCK and DAT.
  - lr_prev holds LRCK as sampled at the previous rise. An LRCK edge is "LRCK differs from lr_prev at this rise".
- FSM states: IDLE, DELAY, SHIFT, PAD.
  - IDLE: on a rise with an LRCK 1->0 edge (start of left) and enable=1 -> DELAY, channel=L. Any other edge is ignored, so capture always aligns to a left word.
  - DELAY: the next rise is the I2S one-bit delay. Discard the bit, clear shreg and bitcnt, -> SHIFT.
  - SHIFT: each rise shifts DAT into shreg LSB and increments bitcnt.
    - When bitcnt reaches SAMPLE_WIDTH: if channel=L, latch left_hold and go to PAD; if channel=R, push {left_hold, shreg} and go to PAD.
    - An LRCK edge before bitcnt reaches SAMPLE_WIDTH: set framing_err, discard the partial pair, go to IDLE. If that edge is 1->0, go straight to DELAY instead (resync on the same rise).
  - PAD: ignore bits until an LRCK edge.
    - 0->1 edge: channel=R, -> DELAY.
    - 1->0 edge: channel=L, -> DELAY.
- enable=0: FSM forced to IDLE the next Clk cycle and any partial pair is discarded. FIFO contents stay readable.
- FIFO:
  - A pop happens on any cycle with sample_valid=1 and sample_ready=1. LData/RData update the cycle after the pop.
  - Push latency: a pair completed on rise cycle t is visible at the outputs at t+1 if the FIFO was empty.
  - Push while full with no pop: pair dropped, contents unchanged, overflow set.
  - Push and pop in the same cycle while full: both take effect, no overflow.
  - Push and pop in the same cycle while empty is impossible (valid=0).
- Flags: clear_flags clears both flags. If a set event occurs in the same cycle as clear_flags, the set wins.
- Counters: bitcnt is sized for SAMPLE_WIDTH+1 and saturates in PAD. Read/write pointers wrap modulo FIFO_DEPTH, with an extra bit used to tell full from empty.

Test Plan:
- Reset then enable=1; drive I2S, BCLK=Clk/16, 32 BCLK per channel, L=16'hA5C3, R=16'h0F01 -> one pair with LData=A5C3, RData=0F01, sample_valid=1; flags remain 0.
- Stream 6 frames (L=16'h0001..0006, R=16'h8001..8006) with sample_ready=0 -> first 4 pairs retained in order, overflow=1 after the 5th. Then hold sample_ready=1 -> pops return 0001/8001..0004/8004, then sample_valid=0.
- With FIFO full, assert sample_ready on the exact cycle the 5th pair completes -> pair accepted, overflow stays 0, occupancy stays 4.
- Drop LRCK back to 0 after 10 bits of a right word -> framing_err=1, no push, next frame L=16'h1234/R=16'h5678 captured correctly; clear_flags -> framing_err=0.
- Start the stream mid-right-word and pulse enable=0 for 3 cycles mid-left-word -> no partial pair is pushed, and capture resumes on the next LRCK falling edge.
- Assert Reset=0 asynchronously mid-shift with 2 pairs buffered -> outputs 0 immediately, FIFO empty, next full frame captured correctly.
